// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, pre-decodes JAL/B-type words for prediction and
// accepts EX redirects. Define IF_BHT_EN for a 2-bit BHT; otherwise B-types use static BTFN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_mem_read_data,
  input  logic        EX_flush,
  input  logic [31:0] EX_redirect_pc,
  input  logic        EX_MEM_stall,
  input  logic        EX_branch_valid,
  input  logic [31:0] EX_branch_pc,
  input  logic        EX_branch_taken,
  output logic [31:0] inst_mem_addr,
  output logic [31:0] IF_pc,
  output logic        IF_take,
  output logic [31:0] IF_pred_target
);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [31:0] pc_q, pc_d;
  logic [31:0] predImm;
  logic        isBranch, isJal, branchTake;

  assign isBranch = (inst_mem_read_data[6:0] == OpBranch);
  assign isJal    = (inst_mem_read_data[6:0] == OpJal);

  always_comb begin
    predImm = 32'd0;
    if (isBranch)
      predImm = {{19{inst_mem_read_data[31]}}, inst_mem_read_data[31], inst_mem_read_data[7],
                 inst_mem_read_data[30:25], inst_mem_read_data[11:8], 1'b0};
    else if (isJal)
      predImm = {{11{inst_mem_read_data[31]}}, inst_mem_read_data[31], inst_mem_read_data[19:12],
                 inst_mem_read_data[20], inst_mem_read_data[30:21], 1'b0};
  end

`ifdef IF_BHT_EN
  localparam int BhtN = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [BhtN];
  logic [1:0]           bht_d;
  logic [BHT_IDX_W-1:0] lookupIdx, updateIdx;
  logic                 unused_ok;

  assign lookupIdx  = pc_q[BHT_IDX_W+1:2];
  assign updateIdx  = EX_branch_pc[BHT_IDX_W+1:2];
  assign branchTake = bht_q[lookupIdx][1];
  assign unused_ok  = ^{EX_redirect_pc[1:0], EX_branch_pc};

  // Saturating 2-bit counter step for the entry named by the resolving branch
  always_comb begin
    bht_d = bht_q[updateIdx];
    if (EX_branch_taken && bht_q[updateIdx] != 2'b11)
      bht_d = bht_q[updateIdx] + 2'b01;
    else if (!EX_branch_taken && bht_q[updateIdx] != 2'b00)
      bht_d = bht_q[updateIdx] - 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BhtN; i++)
        bht_q[i] <= 2'b01;
    end else if (EX_branch_valid) begin
      bht_q[updateIdx] <= bht_d;
    end
  end
`else
  logic unused_ok;

  // Backward branches (negative offset) predicted taken, forward not-taken
  assign branchTake = predImm[31];
  assign unused_ok  = ^{EX_redirect_pc[1:0], EX_branch_valid, EX_branch_pc, EX_branch_taken};
`endif

  assign IF_take        = isJal | (isBranch & branchTake);
  assign IF_pred_target = pc_q + predImm;
  assign inst_mem_addr  = pc_q;
  assign IF_pc          = pc_q;

  // Flush beats stall: a redirect must land even while the pipe is frozen
  always_comb begin
    if (EX_flush)
      pc_d = {EX_redirect_pc[31:2], 2'b00};
    else if (EX_MEM_stall)
      pc_d = pc_q;
    else if (IF_take)
      pc_d = IF_pred_target;
    else
      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard of expected addr/take/target per cycle.
// Expectations follow IF_BHT_EN when the bench is compiled with it defined.
module tb_if_fetch_stage;

`ifdef IF_BHT_EN
  localparam bit Bht = 1'b1;
`else
  localparam bit Bht = 1'b0;
`endif

  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] Jal  = 32'h0200_006F;
  localparam logic [31:0] Bneg = 32'hFE00_0CE3;
  localparam logic [31:0] Bpos = 32'h0000_0463;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_mem_read_data;
  logic        EX_flush;
  logic [31:0] EX_redirect_pc;
  logic        EX_MEM_stall;
  logic        EX_branch_valid;
  logic [31:0] EX_branch_pc;
  logic        EX_branch_taken;
  logic [31:0] inst_mem_addr;
  logic [31:0] IF_pc;
  logic        IF_take;
  logic [31:0] IF_pred_target;

  typedef struct packed {
    logic [31:0] addr;
    logic        take;
    logic [31:0] target;
  } exp_t;

  exp_t sbQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .inst_mem_read_data(inst_mem_read_data),
    .EX_flush(EX_flush), .EX_redirect_pc(EX_redirect_pc), .EX_MEM_stall(EX_MEM_stall),
    .EX_branch_valid(EX_branch_valid), .EX_branch_pc(EX_branch_pc),
    .EX_branch_taken(EX_branch_taken), .inst_mem_addr(inst_mem_addr), .IF_pc(IF_pc),
    .IF_take(IF_take), .IF_pred_target(IF_pred_target)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag);
    exp_t e;
    vectors++;
    assert (sbQ.size() != 0) else begin
      miscompares++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      vectors += 3;
      assert (inst_mem_addr === e.addr) else begin
        miscompares++;
        $error("[TB] FAIL %s_addr observed=%h expected=%h", tag, inst_mem_addr, e.addr);
      end
      assert (IF_pc === e.addr) else begin
        miscompares++;
        $error("[TB] FAIL %s_pc observed=%h expected=%h", tag, IF_pc, e.addr);
      end
      assert (IF_take === e.take) else begin
        miscompares++;
        $error("[TB] FAIL %s_take observed=%b expected=%b", tag, IF_take, e.take);
      end
      vectors++;
      assert (IF_pred_target === e.target) else begin
        miscompares++;
        $error("[TB] FAIL %s_target observed=%h expected=%h", tag, IF_pred_target, e.target);
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] instr,
                               input logic flush, input logic [31:0] redir, input logic stall,
                               input logic bv, input logic [31:0] bpc, input logic bt,
                               input logic [31:0] expAddr, input logic expTake,
                               input logic [31:0] expTarget);
    exp_t e;
    inst_mem_read_data = instr;
    EX_flush           = flush;
    EX_redirect_pc     = redir;
    EX_MEM_stall       = stall;
    EX_branch_valid    = bv;
    EX_branch_pc       = bpc;
    EX_branch_taken    = bt;
    e.addr   = expAddr;
    e.take   = expTake;
    e.target = expTarget;
    sbQ.push_back(e);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    applyStimulus("in_reset", Nop, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    reset = 1'b0;

    // Sequential NOP fetch, then JAL redirect
    applyStimulus("seq0", Nop, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    applyStimulus("seq4", Nop, 0, 0, 0, 0, 0, 0, 32'h4, 0, 32'h4);
    applyStimulus("seq8", Nop, 0, 0, 0, 0, 0, 0, 32'h8, 0, 32'h8);
    applyStimulus("seqC", Nop, 0, 0, 0, 0, 0, 0, 32'hC, 0, 32'hC);
    applyStimulus("jal", Jal, 0, 0, 0, 0, 0, 0, 32'h10, 1, 32'h30);
    applyStimulus("misalign_flush", Nop, 1, 32'h43, 0, 0, 0, 0, 32'h30, 0, 32'h30);

    // Backward branch: BHT starts weakly not-taken, BTFN predicts taken
    applyStimulus("bneg_fresh", Bneg, 0, 0, 0, 0, 0, 0, 32'h40, !Bht, 32'h38);
    applyStimulus("flush_stall", Nop, 1, 32'h40, 1, 0, 0, 0, Bht ? 32'h44 : 32'h38, 0,
                  Bht ? 32'h44 : 32'h38);
    applyStimulus("train1_old", Bneg, 0, 0, 1, 1, 32'h40, 1, 32'h40, !Bht, 32'h38);
    applyStimulus("train2", Bneg, 0, 0, 1, 1, 32'h40, 1, 32'h40, 1, 32'h38);
    applyStimulus("bneg_trained", Bneg, 0, 0, 0, 0, 0, 0, 32'h40, 1, 32'h38);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall_hold", Nop, 0, 0, 1, 0, 0, 0, 32'h38, 0, 32'h38);
    applyStimulus("post_stall", Nop, 0, 0, 0, 0, 0, 0, 32'h38, 0, 32'h38);
    applyStimulus("redir_100", Nop, 1, 32'h100, 1, 0, 0, 0, 32'h3C, 0, 32'h3C);

    // Saturate index 0 high, then one not-taken step back to 10
    for (int i = 0; i < 6; i++)
      applyStimulus("sat_up", Bneg, 0, 0, 1, 1, 32'h100, (i < 5), 32'h100,
                    Bht ? (i != 0) : 1'b1, 32'hF8);
    applyStimulus("sat_10", Bneg, 0, 0, 1, 0, 0, 0, 32'h100, 1, 32'hF8);

    // Saturate index 1 low; one taken step from 00 must still predict not-taken
    for (int i = 0; i < 4; i++)
      applyStimulus("sat_down", Nop, 0, 0, 1, 1, 32'h104, 0, 32'h100, 0, 32'h100);
    applyStimulus("from_00", Nop, 1, 32'h104, 1, 1, 32'h104, 1, 32'h100, 0, 32'h100);
    applyStimulus("sat_00", Bneg, 1, 32'h80, 1, 0, 0, 0, 32'h104, !Bht, 32'hFC);

    // Train index 32, then an async reset must clear it
    applyStimulus("tr80a", Bneg, 0, 0, 1, 1, 32'h80, 1, 32'h80, !Bht, 32'h78);
    applyStimulus("tr80b", Bneg, 0, 0, 1, 1, 32'h80, 1, 32'h80, 1, 32'h78);
    applyStimulus("tr80c", Bneg, 0, 0, 1, 0, 0, 0, 32'h80, 1, 32'h78);
    inst_mem_read_data = Nop;
    EX_MEM_stall = 1'b0;
    reset = 1'b1;
    e.addr = 32'h0; e.take = 1'b0; e.target = 32'h0;
    sbQ.push_back(e);
    #1;
    checkOutput("async_reset");
    #2;
    reset = 1'b0;
    applyStimulus("post_reset", Nop, 1, 32'h80, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    applyStimulus("bht_cleared", Bneg, 0, 0, 1, 0, 0, 0, 32'h80, !Bht, 32'h78);
    applyStimulus("nop80", Nop, 0, 0, 0, 0, 0, 0, 32'h80, 0, 32'h80);
    applyStimulus("bpos", Bpos, 0, 0, 0, 0, 0, 0, 32'h84, 0, 32'h8C);
    applyStimulus("to_top", Nop, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h88, 0, 32'h88);
    applyStimulus("top", Nop, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    applyStimulus("wrap", Nop, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
